// File: rtl/mem_bus_arbiter.sv
// Two-port memory bus arbiter: CPU (port 0) and debug/loader (port 1) share one
// word-addressed memory port with round-robin tie-breaking and fixed wait states.
module mem_bus_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16
) (
    input  logic              clock,
    input  logic              reset_L,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_done,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re_L,
    output logic              mem_we_L,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} stateT;
    typedef enum logic {CPU = 1'b0, DBG = 1'b1} portT;

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(1);
    localparam logic [3:0]        CNT_INIT  = 4'(WAIT_CYCLES - 1);

    stateT             state;
    portT              owner;
    portT              lastGrant;
    logic              weQ;
    logic [3:0]        cnt;

    logic              pickDbg;
    logic              selWe;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selWdata;

    // Debug wins when alone, or on a tie when the CPU was granted last.
    always_comb begin
        pickDbg  = dbg_req && (!cpu_req || lastGrant == CPU);
        selWe    = pickDbg ? dbg_we    : cpu_we;
        selAddr  = pickDbg ? dbg_addr  : cpu_addr;
        selWdata = pickDbg ? dbg_wdata : cpu_wdata;
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state     <= IDLE;
            owner     <= CPU;
            lastGrant <= DBG;
            weQ       <= 1'b0;
            cnt       <= '0;
            mem_re_L  <= 1'b1;
            mem_we_L  <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            cpu_done  <= 1'b0;
            dbg_done  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req || dbg_req) begin
                        owner     <= pickDbg ? DBG : CPU;
                        lastGrant <= pickDbg ? DBG : CPU;
                        weQ       <= selWe;
                        mem_addr  <= selAddr & WORD_MASK;
                        mem_wdata <= selWdata;
                        mem_re_L  <= selWe;
                        mem_we_L  <= ~selWe;
                        cnt       <= CNT_INIT;
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        mem_re_L <= 1'b1;
                        mem_we_L <= 1'b1;
                        if (!weQ) rdata <= mem_rdata;
                        cpu_done <= (owner == CPU);
                        dbg_done <= (owner == DBG);
                        state    <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    cpu_done <= 1'b0;
                    dbg_done <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a scoreboard of expected transactions is
// checked against bus activity and done pulses; a second instance runs WAIT_CYCLES=1.
module tb_mem_bus_arbiter;

    typedef struct {
        logic        port;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } txnT;

    logic        clock;
    logic        reset_L;
    logic        cpuReq, cpuWe, cpuDone, dbgReq, dbgWe, dbgDone;
    logic [15:0] cpuAddr, cpuWdata, dbgAddr, dbgWdata;
    logic [15:0] rdata, memAddr, memWdata, memRdata;
    logic        memReL, memWeL, busy;

    logic        cpuReq1, cpuDone1, dbgDone1, memReL1, memWeL1, busy1;
    logic [15:0] cpuAddr1, rdata1, memAddr1, memWdata1, memRdata1;
    logic        zeroBit;
    logic [15:0] zeroWord;

    logic [15:0] memBase;
    txnT         sb[$];
    int          checks;
    int          failures;
    int          cyc;
    int          lowCnt;
    int          lastDone;

    assign memRdata  = memBase ^ memAddr;
    assign memRdata1 = memBase ^ memAddr1;
    assign zeroBit   = 1'b0;
    assign zeroWord  = 16'h0000;

    mem_bus_arbiter #(.WAIT_CYCLES(2), .ADDR_W(16), .DATA_W(16)) u0 (
        .clock(clock), .reset_L(reset_L),
        .cpu_req(cpuReq), .cpu_we(cpuWe), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata), .cpu_done(cpuDone),
        .dbg_req(dbgReq), .dbg_we(dbgWe), .dbg_addr(dbgAddr), .dbg_wdata(dbgWdata), .dbg_done(dbgDone),
        .rdata(rdata), .mem_addr(memAddr), .mem_wdata(memWdata),
        .mem_re_L(memReL), .mem_we_L(memWeL), .mem_rdata(memRdata), .busy(busy)
    );

    mem_bus_arbiter #(.WAIT_CYCLES(1), .ADDR_W(16), .DATA_W(16)) u1 (
        .clock(clock), .reset_L(reset_L),
        .cpu_req(cpuReq1), .cpu_we(zeroBit), .cpu_addr(cpuAddr1), .cpu_wdata(zeroWord), .cpu_done(cpuDone1),
        .dbg_req(zeroBit), .dbg_we(zeroBit), .dbg_addr(zeroWord), .dbg_wdata(zeroWord), .dbg_done(dbgDone1),
        .rdata(rdata1), .mem_addr(memAddr1), .mem_wdata(memWdata1),
        .mem_re_L(memReL1), .mem_we_L(memWeL1), .mem_rdata(memRdata1), .busy(busy1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic push(input logic port, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] rd);
        txnT t;
        t.port = port; t.we = we; t.addr = addr; t.wdata = wdata; t.rdata = rd;
        sb.push_back(t);
    endtask

    task automatic checkResetState(input string tag);
        check({tag, "_reL"},  32'(memReL),   32'd1);
        check({tag, "_weL"},  32'(memWeL),   32'd1);
        check({tag, "_busy"}, 32'(busy),     32'd0);
        check({tag, "_cDn"},  32'(cpuDone),  32'd0);
        check({tag, "_dDn"},  32'(dbgDone),  32'd0);
        check({tag, "_rd"},   32'(rdata),    32'd0);
        check({tag, "_addr"}, 32'(memAddr),  32'd0);
        check({tag, "_wd"},   32'(memWdata), 32'd0);
    endtask

    // Bus monitor: enable exclusivity, bus contents during access, done pulses vs scoreboard.
    always @(negedge clock) begin
        if (!reset_L) begin
            lowCnt = 0;
        end else begin
            check("bothEnLow", 32'(!memReL && !memWeL), 32'd0);
            check("bothDone",  32'(cpuDone && dbgDone), 32'd0);
            if (!memReL || !memWeL) begin
                lowCnt++;
                if (sb.size() == 0) begin
                    check("unexpectedAccess", 32'(sb.size()), 32'd1);
                end else begin
                    check("busAddr", 32'(memAddr), 32'(sb[0].addr));
                    check("busReL",  32'(memReL),  32'(sb[0].we));
                    check("busWeL",  32'(memWeL),  32'(!sb[0].we));
                    if (sb[0].we) check("busWdata", 32'(memWdata), 32'(sb[0].wdata));
                end
            end
            if (cpuDone || dbgDone) begin
                if (sb.size() == 0) begin
                    check("unexpectedDone", 32'(sb.size()), 32'd1);
                end else begin
                    txnT e;
                    e = sb.pop_front();
                    check("donePort",  32'(dbgDone), 32'(e.port));
                    check("doneRdata", 32'(rdata),   32'(e.rdata));
                    check("enLowCyc",  32'(lowCnt),  32'd2);
                end
                lowCnt = 0;
            end
        end
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0; cyc = 0; lowCnt = 0; lastDone = 0;
        reset_L = 1'b1;
        cpuReq = 0; cpuWe = 0; cpuAddr = '0; cpuWdata = '0;
        dbgReq = 0; dbgWe = 0; dbgAddr = '0; dbgWdata = '0;
        cpuReq1 = 0; cpuAddr1 = '0; memBase = '0;
        #1 reset_L = 1'b0;
        #2 checkResetState("rst0");
        step();
        reset_L = 1'b1;

        // 1: CPU read 0x0204 returns 0xBEEF
        memBase = 16'hBEEF ^ 16'h0204;
        cpuReq = 1; cpuWe = 0; cpuAddr = 16'h0204;
        push(1'b0, 1'b0, 16'h0204, 16'h0000, 16'hBEEF);
        step();
        check("t1_reL_c1", 32'(memReL), 32'd0);
        check("t1_busy",   32'(busy),   32'd1);
        step();
        check("t1_reL_c2", 32'(memReL), 32'd0);
        check("t1_noDone", 32'(cpuDone), 32'd0);
        step();
        check("t1_done_c3", 32'(cpuDone), 32'd1);
        check("t1_rdata",   32'(rdata),   32'hBEEF);
        check("t1_reL_c3",  32'(memReL),  32'd1);
        cpuReq = 0;
        step();
        check("t1_doneOff", 32'(cpuDone), 32'd0);
        check("t1_idle",    32'(busy),    32'd0);

        // 2: debug write to an odd address, word-aligned on the bus
        dbgReq = 1; dbgWe = 1; dbgAddr = 16'h0611; dbgWdata = 16'h1234;
        push(1'b1, 1'b1, 16'h0610, 16'h1234, 16'hBEEF);
        step();
        check("t2_addr",  32'(memAddr),  32'h0610);
        check("t2_wdata", 32'(memWdata), 32'h1234);
        check("t2_weL",   32'(memWeL),   32'd0);
        step();
        step();
        check("t2_done",  32'(dbgDone), 32'd1);
        check("t2_rdata", 32'(rdata),   32'hBEEF);
        dbgReq = 0;
        step();
        check("t2_doneOff", 32'(dbgDone), 32'd0);

        // 3: simultaneous requests after reset alternate starting with CPU
        reset_L = 1'b0;
        #2 checkResetState("rst3");
        step();
        reset_L = 1'b1;
        memBase = 16'h0000;
        cpuWe = 0; cpuAddr = 16'h0100; dbgWe = 0; dbgAddr = 16'h0300;
        push(1'b0, 1'b0, 16'h0100, 16'h0000, 16'h0100);
        push(1'b1, 1'b0, 16'h0300, 16'h0000, 16'h0300);
        push(1'b0, 1'b0, 16'h0100, 16'h0000, 16'h0100);
        push(1'b1, 1'b0, 16'h0300, 16'h0000, 16'h0300);
        cpuReq = 1; dbgReq = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t3_busy", 32'(busy), 32'd1);
            step();
            step();
            check("t3_cpuDone", 32'(cpuDone), 32'(k % 2 == 0));
            check("t3_dbgDone", 32'(dbgDone), 32'(k % 2 == 1));
            if (k > 0) check("t3_spacing", 32'(cyc - lastDone), 32'd4);
            lastDone = cyc;
            if (k == 3) begin
                cpuReq = 0; dbgReq = 0;
            end
            step();
        end

        // 4: request dropped mid-read still completes
        memBase = 16'h1111;
        cpuReq = 1; cpuWe = 0; cpuAddr = 16'h0402;
        push(1'b0, 1'b0, 16'h0402, 16'h0000, 16'h1513);
        step();
        cpuReq = 0;
        step();
        check("t4_reL_c2", 32'(memReL), 32'd0);
        step();
        check("t4_done", 32'(cpuDone), 32'd1);
        check("t4_rdata", 32'(rdata), 32'h1513);
        step();
        step();
        check("t4_stayIdle", 32'(busy), 32'd0);
        check("t4_reL", 32'(memReL), 32'd1);

        // 5: reset during a write drops it without a done pulse
        dbgReq = 1; dbgWe = 1; dbgAddr = 16'h0800; dbgWdata = 16'hCAFE;
        push(1'b1, 1'b1, 16'h0800, 16'hCAFE, 16'h1513);
        step();
        step();
        check("t5_weL_c2", 32'(memWeL), 32'd0);
        reset_L = 1'b0;
        #1;
        void'(sb.pop_back());
        check("t5_weL", 32'(memWeL), 32'd1);
        check("t5_reL", 32'(memReL), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_rdata", 32'(rdata), 32'd0);
        dbgReq = 0;
        step();
        reset_L = 1'b1;
        step();
        step();
        check("t5_idleBusy", 32'(busy), 32'd0);
        check("t5_noDone", 32'(dbgDone), 32'd0);

        // 6: single wait-state build
        memBase = 16'h5A5A;
        cpuReq1 = 1; cpuAddr1 = 16'h0A0B;
        step();
        check("t6_reL_c1", 32'(memReL1), 32'd0);
        check("t6_addr", 32'(memAddr1), 32'h0A0A);
        step();
        check("t6_done_c2", 32'(cpuDone1), 32'd1);
        check("t6_reL_c2", 32'(memReL1), 32'd1);
        check("t6_rdata", 32'(rdata1), 32'(16'h5A5A ^ 16'h0A0A));
        cpuReq1 = 0;
        step();
        check("t6_doneOff", 32'(cpuDone1), 32'd0);

        check("sbEmpty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
